// File: rtl/ft245_pkg.sv
// Shared encodings for the FT245 asynchronous FIFO slave: FSM states and error codes.
package ft245_pkg;

  typedef enum logic [1:0] {
    R_IDLE      = 2'd0,
    R_ARMED     = 2'd1,
    R_ACTIVE    = 2'd2,
    R_PRECHARGE = 2'd3
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_ACTIVE    = 2'd1,
    W_HOLD      = 2'd2,
    W_PRECHARGE = 2'd3
  } wr_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RD_EMPTY = 2'd1;
  localparam logic [1:0] ERR_WR_FULL  = 2'd2;
  localparam logic [1:0] ERR_COLLIDE  = 2'd3;

  // Collision outranks the single-strobe violations.
  function automatic logic [1:0] err_classify(
    input logic rd_low,
    input logic wr_low,
    input logic rd_unarmed,
    input logic wr_busy_fall
  );
    if (rd_low && wr_low) begin
      return ERR_COLLIDE;
    end else if (rd_low && rd_unarmed) begin
      return ERR_RD_EMPTY;
    end else if (wr_busy_fall) begin
      return ERR_WR_FULL;
    end else begin
      return ERR_NONE;
    end
  endfunction

endpackage

// File: rtl/ft245_sync_fifo.sv
// Single-clock FIFO with count-based full/empty and wrap-around pointers (show-ahead read).
module ft245_sync_fifo #(
  parameter int pAW = 4,
  parameter int pDW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [pDW-1:0] push_data,
  input  logic           pop,
  output logic [pDW-1:0] pop_data,
  output logic           full,
  output logic           empty
);

  localparam logic [pAW:0] DEPTH = (pAW+1)'(1) << pAW;

  logic [pDW-1:0] mem_r [2**pAW];
  logic [pAW-1:0] wr_ptr_r;
  logic [pAW-1:0] rd_ptr_r;
  logic [pAW:0]   count_r;
  logic           push_ok_s;
  logic           pop_ok_s;

  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign full      = (count_r == DEPTH);
  assign empty     = (count_r == (pAW+1)'(0));
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage array; contents are irrelevant until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + pAW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + pAW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (pAW+1)'(1);
        2'b01:   count_r <= count_r - (pAW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ft245_async_slave.sv
// Chip-side FT245 asynchronous FIFO responder. Define FT245_SLAVE_LOOPBACK_EN to echo
// every byte written on WR# back into the read FIFO instead of the oDevData stream.
module ft245_async_slave
  import ft245_pkg::*;
#(
  parameter int pFifoAW      = 4,
  parameter int pRxfHighClks = 2,
  parameter int pTxeHighClks = 2,
  parameter int pSyncStages  = 2
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iHostData,
  input  logic       iHostValid,
  output logic       oHostReady,
  output logic [7:0] oDevData,
  output logic       oDevValid,
  input  logic       iDevReady,
  inout  wire  [7:0] ioFifoData,
  output logic       oRxF_n,
  output logic       oTxE_n,
  input  logic       iRd_n,
  input  logic       iWr_n,
  output logic       oProtoErr,
  output logic [1:0] oErrCode
);

  rd_state_t              r_state_r;
  wr_state_t              w_state_r;
  logic [pSyncStages-1:0] rd_sync_r, wr_sync_r;
  logic [7:0]             data_sync_r [pSyncStages];
  logic                   rd_last_r, wr_last_r;
  logic                   rd_s, wr_s, rd_fall_s, rd_rise_s, wr_fall_s, wr_rise_s;
  logic [7:0]             head_r, dev_data_r, rd_cnt_r, wr_cnt_r;
  logic                   armed_r, rxf_n_r, txe_n_r, dev_valid_r, err_r;
  logic [1:0]             code_r, new_code_s;
  logic                   fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s, hold_done_s;
  logic [7:0]             fifo_wdata_s, fifo_rdata_s;

  assign rd_s      = rd_sync_r[pSyncStages-1];
  assign wr_s      = wr_sync_r[pSyncStages-1];
  assign rd_fall_s = rd_last_r & ~rd_s;
  assign rd_rise_s = ~rd_last_r & rd_s;
  assign wr_fall_s = wr_last_r & ~wr_s;
  assign wr_rise_s = ~wr_last_r & wr_s;

  // Drive only while armed and RD# is low; reset drops the bus in the same cycle.
  assign ioFifoData = (!iRd_n && armed_r && !iRst) ? head_r : 8'hzz;

  // Strobe and data synchronizers; data rides alongside WR# so they stay aligned.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rd_sync_r <= '1;
      wr_sync_r <= '1;
      rd_last_r <= 1'b1;
      wr_last_r <= 1'b1;
      for (int i = 0; i < pSyncStages; i++) data_sync_r[i] <= 8'h00;
    end else begin
      rd_sync_r <= {rd_sync_r[pSyncStages-2:0], iRd_n};
      wr_sync_r <= {wr_sync_r[pSyncStages-2:0], iWr_n};
      rd_last_r <= rd_s;
      wr_last_r <= wr_s;
      data_sync_r[0] <= ioFifoData;
      for (int i = 1; i < pSyncStages; i++) data_sync_r[i] <= data_sync_r[i-1];
    end
  end

  assign fifo_pop_s = (r_state_r == R_ACTIVE) && rd_rise_s;

`ifdef FT245_SLAVE_LOOPBACK_EN
  logic unused_s;
  assign unused_s     = ^{iHostData, iHostValid, iDevReady, dev_valid_r};
  assign hold_done_s  = !fifo_full_s;
  assign fifo_push_s  = (w_state_r == W_HOLD) && !fifo_full_s;
  assign fifo_wdata_s = dev_data_r;
  assign oHostReady   = 1'b0;
  assign oDevValid    = 1'b0;
`else
  assign hold_done_s  = iDevReady;
  assign fifo_push_s  = iHostValid && !fifo_full_s;
  assign fifo_wdata_s = iHostData;
  assign oHostReady   = !fifo_full_s;
  assign oDevValid    = dev_valid_r;
`endif

  ft245_sync_fifo #(.pAW(pFifoAW), .pDW(8)) u_fifo (
    .clk       (iClk),
    .rst       (iRst),
    .push      (fifo_push_s),
    .push_data (fifo_wdata_s),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_rdata_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Read side: arm with the FIFO head, serve one RD# cycle, then hold RXF# high.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state_r <= R_IDLE;
      rxf_n_r   <= 1'b1;
      armed_r   <= 1'b0;
      head_r    <= 8'h00;
      rd_cnt_r  <= 8'd0;
    end else begin
      case (r_state_r)
        R_IDLE: if (!fifo_empty_s) begin
          head_r    <= fifo_rdata_s;
          armed_r   <= 1'b1;
          rxf_n_r   <= 1'b0;
          r_state_r <= R_ARMED;
        end
        R_ARMED: if (rd_fall_s) r_state_r <= R_ACTIVE;
        R_ACTIVE: if (rd_rise_s) begin
          rxf_n_r   <= 1'b1;
          armed_r   <= 1'b0;
          rd_cnt_r  <= 8'd0;
          r_state_r <= R_PRECHARGE;
        end
        R_PRECHARGE: begin
          if (rd_cnt_r == 8'(pRxfHighClks - 1)) r_state_r <= R_IDLE;
          else rd_cnt_r <= rd_cnt_r + 8'd1;
        end
        default: r_state_r <= R_IDLE;
      endcase
    end
  end

  // Write side: capture on WR# fall, present after WR# rise, precharge TXE#.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      w_state_r   <= W_IDLE;
      txe_n_r     <= 1'b1;
      dev_valid_r <= 1'b0;
      dev_data_r  <= 8'h00;
      wr_cnt_r    <= 8'd0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (wr_fall_s) begin
            dev_data_r <= data_sync_r[pSyncStages-1];
            txe_n_r    <= 1'b1;
            w_state_r  <= W_ACTIVE;
          end else begin
            txe_n_r <= 1'b0;
          end
        end
        W_ACTIVE: if (wr_rise_s) begin
          dev_valid_r <= 1'b1;
          w_state_r   <= W_HOLD;
        end
        W_HOLD: if (hold_done_s) begin
          dev_valid_r <= 1'b0;
          wr_cnt_r    <= 8'd0;
          w_state_r   <= W_PRECHARGE;
        end
        W_PRECHARGE: begin
          if (wr_cnt_r == 8'(pTxeHighClks - 1)) begin
            txe_n_r   <= 1'b0;
            w_state_r <= W_IDLE;
          end else begin
            wr_cnt_r <= wr_cnt_r + 8'd1;
          end
        end
        default: w_state_r <= W_IDLE;
      endcase
    end
  end

  assign new_code_s = err_classify(!rd_s, !wr_s, !armed_r, wr_fall_s && (w_state_r != W_IDLE));

  // Sticky first-error capture.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      err_r  <= 1'b0;
      code_r <= ERR_NONE;
    end else if (!err_r && (new_code_s != ERR_NONE)) begin
      err_r  <= 1'b1;
      code_r <= new_code_s;
    end
  end

  assign oRxF_n    = rxf_n_r;
  assign oTxE_n    = txe_n_r;
  assign oDevData  = dev_data_r;
  assign oProtoErr = err_r;
  assign oErrCode  = code_r;

endmodule

// File: tb/tb_ft245_async_slave.sv
// Self-checking bench for ft245_async_slave: scoreboarded host/bus traffic plus corner sequences.
module tb_ft245_async_slave;

  logic       clk = 1'b0;
  logic       rst, host_valid, dev_ready, rd_n, wr_n, tb_drv;
  logic [7:0] host_data, tb_byte;
  wire        host_ready, dev_valid, rxf_n, txe_n, proto_err;
  wire  [7:0] dev_data, bus;
  wire  [1:0] err_code;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] dev_q[$];

  typedef struct {
    logic [7:0]  data;
    int unsigned delay;
    logic [7:0]  exp_data;
  } wr_vec_t;
  wr_vec_t wr_tab [4];

  always #10 clk = ~clk;

  assign bus = tb_drv ? tb_byte : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus[g]);
  end

  ft245_async_slave dut (
    .iClk(clk), .iRst(rst),
    .iHostData(host_data), .iHostValid(host_valid), .oHostReady(host_ready),
    .oDevData(dev_data), .oDevValid(dev_valid), .iDevReady(dev_ready),
    .ioFifoData(bus), .oRxF_n(rxf_n), .oTxE_n(txe_n),
    .iRd_n(rd_n), .iWr_n(wr_n),
    .oProtoErr(proto_err), .oErrCode(err_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_push(input logic [7:0] b);
    @(negedge clk);
    host_valid = 1'b1;
    host_data  = b;
    chk("host_ready", {31'd0, host_ready}, {31'd0, model_cnt < 16});
    if (model_cnt < 16) begin
      exp_q.push_back(b);
      model_cnt++;
    end
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic master_read();
    int n;
    int hi;
    logic [7:0] exp;
    n = 0;
    while (rxf_n !== 1'b0 && n < 60) begin @(negedge clk); n++; end
    chk("rxf_low_wait", {31'd0, rxf_n}, 32'd0);
    rd_n = 1'b0;
    @(negedge clk);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hEE;
    chk("read_data", {24'd0, bus}, {24'd0, exp});
    repeat (3) @(negedge clk);
    rd_n = 1'b1;
    #1 chk("bus_z_rd_high", {24'd0, bus}, 32'hFF);
    model_cnt--;
    n = 0;
    while (rxf_n !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("rxf_rise", {31'd0, rxf_n}, 32'd1);
    if (model_cnt > 0) begin
      hi = 0;
      while (rxf_n === 1'b1 && hi < 20) begin
        chk("bus_z_precharge", {24'd0, bus}, 32'hFF);
        hi++;
        @(negedge clk);
      end
      chk("rxf_high_gap", {31'd0, (hi >= 2) && (hi < 20)}, 32'd1);
    end
  endtask

  task automatic master_write(input logic [7:0] b);
    int n;
    n = 0;
    while (txe_n !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk("txe_low_wait", {31'd0, txe_n}, 32'd0);
    tb_byte = b;
    tb_drv  = 1'b1;
    @(negedge clk);
    wr_n = 1'b0;
    n = 0;
    while (txe_n !== 1'b1 && n < 3) begin @(negedge clk); n++; end
    chk("txe_rise_3clk", {31'd0, txe_n}, 32'd1);
    repeat (2) @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    tb_drv = 1'b0;
  endtask

  task automatic dev_accept(input int unsigned delay);
    int n;
    logic [7:0] exp;
    n = 0;
    while (dev_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("dev_valid_up", {31'd0, dev_valid}, 32'd1);
    exp = (dev_q.size() > 0) ? dev_q.pop_front() : 8'hEE;
    for (int k = 0; k < int'(delay); k++) begin
      chk("dev_valid_hold", {31'd0, dev_valid}, 32'd1);
      chk("dev_data_hold", {24'd0, dev_data}, {24'd0, exp});
      chk("txe_hold", {31'd0, txe_n}, 32'd1);
      @(negedge clk);
    end
    dev_ready = 1'b1;
    chk("dev_data", {24'd0, dev_data}, {24'd0, exp});
    @(negedge clk);
    dev_ready = 1'b0;
    chk("dev_valid_drop", {31'd0, dev_valid}, 32'd0);
    chk("txe_pre1", {31'd0, txe_n}, 32'd1);
    @(negedge clk);
    chk("txe_pre2", {31'd0, txe_n}, 32'd1);
    n = 0;
    while (txe_n !== 1'b0 && n < 6) begin @(negedge clk); n++; end
    chk("txe_return", {31'd0, txe_n}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rd_n = 1'b1; wr_n = 1'b1; host_valid = 1'b0; dev_ready = 1'b0; tb_drv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    dev_q.delete();
    model_cnt = 0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_tab[0] = '{data: 8'h3C, delay: 3, exp_data: 8'h3C};
    wr_tab[1] = '{data: 8'h00, delay: 0, exp_data: 8'h00};
    wr_tab[2] = '{data: 8'hFF, delay: 1, exp_data: 8'hFF};
    wr_tab[3] = '{data: 8'h81, delay: 5, exp_data: 8'h81};

    rst = 1'b1; rd_n = 1'b1; wr_n = 1'b1; host_valid = 1'b0; host_data = 8'h00;
    dev_ready = 1'b0; tb_drv = 1'b0; tb_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rxf", {31'd0, rxf_n}, 32'd1);
    chk("rst_txe", {31'd0, txe_n}, 32'd1);
    chk("rst_bus_z", {24'd0, bus}, 32'hFF);
    chk("rst_dev_valid", {31'd0, dev_valid}, 32'd0);
    chk("rst_dev_data", {24'd0, dev_data}, 32'd0);
    chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("txe_idle_low", {31'd0, txe_n}, 32'd0);

`ifdef FT245_SLAVE_LOOPBACK_EN
    for (int i = 0; i < 16; i++) begin
      master_write(8'(i));
      exp_q.push_back(8'(i));
      model_cnt++;
      chk("lb_dev_valid", {31'd0, dev_valid}, 32'd0);
      chk("lb_host_ready", {31'd0, host_ready}, 32'd0);
    end
    for (int i = 0; i < 16; i++) begin
      master_read();
      chk("lb_dev_valid_rd", {31'd0, dev_valid}, 32'd0);
    end
`else
    chk("rst_host_ready", {31'd0, host_ready}, 32'd1);

    host_push(8'h5A);
    host_push(8'hA5);
    master_read();
    master_read();

    for (int i = 0; i < 4; i++) begin
      dev_q.push_back(wr_tab[i].exp_data);
      master_write(wr_tab[i].data);
      dev_accept(wr_tab[i].delay);
    end

    for (int i = 0; i < 16; i++) host_push(8'(i * 3 + 1));
    host_push(8'h77);
    master_read();
    @(negedge clk);
    chk("ready_after_read", {31'd0, host_ready}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      host_push(8'(64 + i));
      master_read();
    end
    while (model_cnt > 0) master_read();

    rd_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("err_bus_z", {24'd0, bus}, 32'hFF);
    end
    rd_n = 1'b1;
    @(negedge clk);
    chk("err_flag", {31'd0, proto_err}, 32'd1);
    chk("err_code_rd", {30'd0, err_code}, 32'd1);
    rd_n = 1'b0;
    wr_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("collide_bus_z", {24'd0, bus}, 32'hFF);
    end
    rd_n = 1'b1;
    wr_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_code_sticky", {30'd0, err_code}, 32'd1);

    do_reset();
    chk("err_cleared", {31'd0, proto_err}, 32'd0);
    host_push(8'h5A);
    begin
      int n;
      n = 0;
      while (rxf_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    end
    rd_n = 1'b0;
    @(negedge clk);
    chk("midrd_drive", {24'd0, bus}, 32'h5A);
    rst = 1'b1;
    #1 chk("midrd_bus_release", {24'd0, bus}, 32'hFF);
    @(negedge clk);
    chk("midrd_rxf", {31'd0, rxf_n}, 32'd1);
    chk("midrd_bus_z", {24'd0, bus}, 32'hFF);
    chk("midrd_ready", {31'd0, host_ready}, 32'd1);
    rd_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      chk("midrd_fifo_empty", {31'd0, rxf_n}, 32'd1);
    end
    chk("midrd_no_err", {31'd0, proto_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
